// File: rtl/hlsm_job_dispatcher.sv
// Operand FIFO plus one-job-at-a-time launcher for the HLSM datapath.
// Results, or a timeout abort, are returned on a valid/ready stream.
module hlsm_job_dispatcher #(
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_a,
  input  logic [DW-1:0]              in_b,
  input  logic [DW-1:0]              in_c,
  output logic                       hl_start,
  output logic [DW-1:0]              hl_a,
  output logic [DW-1:0]              hl_b,
  output logic [DW-1:0]              hl_c,
  input  logic                       hl_done,
  input  logic [DW-1:0]              hl_z,
  input  logic [DW-1:0]              hl_x,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_z,
  output logic [DW-1:0]              out_x,
  output logic                       out_err,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_cnt
);

  // state   | meaning
  // IDLE    | waiting for a queued job; pops FIFO head into hl_a/b/c
  // LAUNCH  | hl_start pulse, timer cleared
  // WAIT    | counting until hl_done or timeout
  // PRESENT | result held on out_* until accepted

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_PRESENT} state_t;

  state_t              state, state_nxt;
  logic [3*DW-1:0]     mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       cnt;
  logic [15:0]         timer;
  logic                push, pop, capture, abort, timer_hit, full;

  assign full      = (cnt == CW'(DEPTH));
  assign in_ready  = !full && !Rst;
  assign push      = in_valid && in_ready;
  assign fifo_cnt  = cnt;
  assign busy      = (state != S_IDLE);
  // Abort on the TIMEOUT-th WAIT cycle, i.e. when the incremented count reaches TIMEOUT.
  assign timer_hit = ((timer + 16'd1) == TIMEOUT_W);

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hl_start  = 1'b0;
    out_valid = 1'b0;
    pop       = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cnt != '0) begin
          pop       = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        hl_start  = !Rst;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (hl_done) begin
          capture   = 1'b1;
          state_nxt = S_PRESENT;
        end else if (timer_hit) begin
          abort     = 1'b1;
          state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        out_valid = !Rst;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b, in_c};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      hl_a    <= '0;
      hl_b    <= '0;
      hl_c    <= '0;
      timer   <= '0;
      out_z   <= '0;
      out_x   <= '0;
      out_err <= 1'b0;
    end else begin
      if (pop) {hl_a, hl_b, hl_c} <= mem[rd_ptr];
      if (state == S_LAUNCH) timer <= '0;
      else if (state == S_WAIT && timer != TIMEOUT_W) timer <= timer + 16'd1;
      if (capture) begin
        out_z   <= hl_z;
        out_x   <= hl_x;
        out_err <= 1'b0;
      end else if (abort) begin
        out_z   <= '0;
        out_x   <= '0;
        out_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hlsm_job_dispatcher.sv
// Directed bench for hlsm_job_dispatcher: single-job vector table plus
// hand-written capacity, backpressure and mid-job reset sequences.
module tb_hlsm_job_dispatcher;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b, in_c;
  logic        hl_start;
  logic [31:0] hl_a, hl_b, hl_c;
  logic        hl_done;
  logic [31:0] hl_z, hl_x;
  logic        out_valid, out_ready;
  logic [31:0] out_z, out_x;
  logic        out_err, busy;
  logic [2:0]  fifo_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hlsm_job_dispatcher #(.DW(32), .DEPTH(4), .TIMEOUT(255)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .hl_start(hl_start), .hl_a(hl_a), .hl_b(hl_b), .hl_c(hl_c),
    .hl_done(hl_done), .hl_z(hl_z), .hl_x(hl_x),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_x(out_x), .out_err(out_err),
    .busy(busy), .fifo_cnt(fifo_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] a, b, c;
    int          done_cyc;   // cycles after hl_start that hl_done is pulsed; 0 = never
    logic [31:0] z, x;
    int          exp_lat;    // cycles from hl_start to out_valid
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v);
    int k;
    int t;
    in_valid = 1'b1;
    in_a = v.a; in_b = v.b; in_c = v.c;
    chk("push_ready", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    k = 1;
    while (!hl_start && k < 10) begin
      tick;
      k++;
    end
    chk("start_latency", 32'(k), 32'd2);
    chk("hl_a", hl_a, v.a);
    chk("hl_b", hl_b, v.b);
    chk("hl_c", hl_c, v.c);
    hl_z = v.z;
    hl_x = v.x;
    t = 0;
    while (!out_valid && t < 400) begin
      tick;
      t++;
      if (t == 1) chk("start_one_cycle", 32'(hl_start), 32'd0);
      hl_done = (t == v.done_cyc);
    end
    hl_done = 1'b0;
    chk("result_latency", 32'(t), 32'(v.exp_lat));
    chk("out_z", out_z, v.exp_err ? 32'd0 : v.z);
    chk("out_x", out_x, v.exp_err ? 32'd0 : v.x);
    chk("out_err", 32'(out_err), 32'(v.exp_err));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("valid_drops", 32'(out_valid), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{a:32'd2, b:32'd3, c:32'd4, done_cyc:5, z:32'h11, x:32'h22, exp_lat:6, exp_err:1'b0};
    vecs[1] = '{a:32'hffffffff, b:32'h0, c:32'ha5a5a5a5, done_cyc:1, z:32'h1234, x:32'h5678, exp_lat:2, exp_err:1'b0};
    vecs[2] = '{a:32'd7, b:32'd8, c:32'd9, done_cyc:255, z:32'hdeadbeef, x:32'hcafef00d, exp_lat:256, exp_err:1'b0};
    vecs[3] = '{a:32'd1, b:32'd1, c:32'd1, done_cyc:0, z:32'h33, x:32'h44, exp_lat:256, exp_err:1'b1};
    vecs[4] = '{a:32'd10, b:32'd20, c:32'd30, done_cyc:256, z:32'h55, x:32'h66, exp_lat:256, exp_err:1'b1};

    Rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0;
    hl_done = 1'b0; hl_z = '0; hl_x = '0; out_ready = 1'b0;
    tick;
    tick;
    chk("rst_hl_start", 32'(hl_start), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_hl_a", hl_a, 32'd0);
    chk("rst_out_z", out_z, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    Rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 5; i++) run_job(vecs[i]);

    // Capacity: six back-to-back pushes, one goes in flight, four queue, last refused.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_a = 32'(10 + i); in_b = 32'(20 + i); in_c = 32'(30 + i);
      chk("cap_in_ready", 32'(in_ready), (i < 5) ? 32'd1 : 32'd0);
      tick;
    end
    in_valid = 1'b0;
    chk("cap_fifo_cnt", 32'(fifo_cnt), 32'd4);
    chk("cap_busy", 32'(busy), 32'd1);
    chk("cap_inflight_a", hl_a, 32'd10);

    // Backpressure: finish the in-flight job, stall PRESENT for 10 cycles.
    hl_done = 1'b1; hl_z = 32'haa; hl_x = 32'hbb;
    tick;
    hl_done = 1'b0; hl_z = 32'h0; hl_x = 32'h0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_z", out_z, 32'haa);
      chk("stall_x", out_x, 32'hbb);
      chk("stall_no_start", 32'(hl_start), 32'd0);
      chk("stall_cnt", 32'(fifo_cnt), 32'd4);
      tick;
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("hs_valid_drop", 32'(out_valid), 32'd0);
    chk("hs_no_start_yet", 32'(hl_start), 32'd0);
    tick;
    chk("hs_restart", 32'(hl_start), 32'd1);
    chk("hs_next_a", hl_a, 32'd11);
    chk("hs_next_c", hl_c, 32'd31);
    chk("hs_cnt", 32'(fifo_cnt), 32'd3);

    // Reset during WAIT with three jobs queued.
    tick;
    tick;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    Rst = 1'b1;
    tick;
    chk("mid_rst_hl_start", 32'(hl_start), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("mid_rst_hl_a", hl_a, 32'd0);
    chk("mid_rst_out_err", 32'(out_err), 32'd0);
    Rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);

    // Late / spurious hl_done while IDLE with an empty FIFO.
    hl_done = 1'b1; hl_z = 32'h99; hl_x = 32'h77;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("idle_done_valid", 32'(out_valid), 32'd0);
      chk("idle_done_busy", 32'(busy), 32'd0);
      chk("idle_done_start", 32'(hl_start), 32'd0);
    end
    hl_done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
